// File: rtl/ibex_data_mem_if.sv
// ibex_data_mem_if: req/gnt/rvalid data port with 33-bit tagged data and 7-bit integrity
interface ibex_data_mem_if;
  logic        req;
  logic        gnt;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [32:0] wdata;
  logic [6:0]  wdata_intg;
  logic        rvalid;
  logic [32:0] rdata;
  logic [6:0]  rdata_intg;
  logic        err;
  modport master (output req, we, be, addr, wdata, wdata_intg, input gnt, rvalid, rdata, rdata_intg, err);
  modport slave (input req, we, be, addr, wdata, wdata_intg, output gnt, rvalid, rdata, rdata_intg, err);
endinterface

// File: rtl/ibex_data_mem_responder.sv
// ibex_data_mem_responder: tagged data memory with fixed read latency and bounded outstanding requests
// Define IBEX_DATA_RESP_INTG_EN to generate read integrity and check write integrity.
module ibex_data_mem_responder #(
  parameter int          Depth          = 1024,
  parameter logic [31:0] MemBase        = 32'h8000_0000,
  parameter int          ReadLatency    = 2,
  parameter int          MaxOutstanding = 2
) (
  input logic             clk_i,
  input logic             rst_ni,
  input logic             stall_i,
  ibex_data_mem_if.slave  bus
);
  localparam int AW = $clog2(Depth);
  localparam int CW = $clog2(MaxOutstanding + 1);
  typedef struct packed {
    logic        v;
    logic        e;
    logic [6:0]  intg;
    logic [32:0] d;
  } resp_t;
`ifdef IBEX_DATA_RESP_INTG_EN
  function automatic logic [6:0] secded_enc(input logic [31:0] d);
    logic [38:0] x;
    x = {7'h0, d};
    return {^(x & 39'h0098505586), ^(x & 39'h002DCC624C), ^(x & 39'h00C2C1323B),
            ^(x & 39'h0031234ED1), ^(x & 39'h00413D89AA), ^(x & 39'h00DEBA8050),
            ^(x & 39'h002606BD25)} ^ 7'h2A;
  endfunction
`endif
  logic [32:0]   mem [Depth];
  logic [CW-1:0] cnt;
  resp_t         pipe [ReadLatency];
  resp_t         resp;
  logic [31:0]   off;
  logic [AW-1:0] idx;
  logic          accept, dec_err, wr_bad, req_err;
  logic [32:0]   wr_word;
  assign off     = bus.addr - MemBase;
  assign idx     = off[AW+1:2];
  assign dec_err = (off >= 32'(4 * Depth)) | (bus.addr[1:0] != 2'b00);
  assign bus.gnt = bus.req & ~stall_i & (cnt < CW'(MaxOutstanding));
  assign accept  = bus.req & bus.gnt;
`ifdef IBEX_DATA_RESP_INTG_EN
  assign wr_bad    = bus.we & (secded_enc(bus.wdata[31:0]) != bus.wdata_intg);
  assign resp.intg = accept ? secded_enc(resp.d[31:0]) : 7'h0;
`else
  logic unused_intg;
  assign unused_intg = ^bus.wdata_intg;
  assign wr_bad      = 1'b0;
  assign resp.intg   = 7'h0;
`endif
  assign req_err = dec_err | wr_bad;
  assign resp.v  = accept;
  assign resp.e  = accept & req_err;
  assign resp.d  = (accept & ~req_err & ~bus.we) ? mem[idx] : 33'h0;
  // Any partial write, including an all-lanes-off one, invalidates the capability tag.
  always_comb begin
    wr_word = mem[idx];
    for (int i = 0; i < 4; i++) wr_word[8*i +: 8] = bus.be[i] ? bus.wdata[8*i +: 8] : mem[idx][8*i +: 8];
    wr_word[32] = (bus.be == 4'hF) & bus.wdata[32];
  end
  always_ff @(posedge clk_i) if (accept & bus.we & ~req_err) mem[idx] <= wr_word;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt <= '0;
      for (int i = 0; i < ReadLatency; i++) pipe[i] <= '0;
    end else begin
      cnt     <= cnt + CW'(accept) - CW'(bus.rvalid);
      pipe[0] <= resp;
      for (int i = 1; i < ReadLatency; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign bus.rvalid     = pipe[ReadLatency-1].v;
  assign bus.err        = pipe[ReadLatency-1].e;
  assign bus.rdata      = pipe[ReadLatency-1].d;
  assign bus.rdata_intg = pipe[ReadLatency-1].intg;
endmodule

// File: tb/tb_ibex_data_mem_responder.sv
// tb_ibex_data_mem_responder: directed vectors plus randomized traffic against a queue-based reference model
module tb_ibex_data_mem_responder;
  localparam logic [31:0] MB = 32'h8000_0000;
  logic clk = 1'b0, rst_n = 1'b0, stall = 1'b0;
  int vectors = 0, miscompares = 0, cyc = 0;
  ibex_data_mem_if bus ();
  ibex_data_mem_responder dut (.clk_i(clk), .rst_ni(rst_n), .stall_i(stall), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [32:0] wdata;
    logic [32:0] exp_rdata;
    logic        exp_err;
  } vec_t;
  typedef struct {
    int          due;
    logic [32:0] d;
    logic        e;
  } exp_t;
  vec_t        tbl [14];
  exp_t        q [$];
  logic [32:0] mmem [1024];
  logic        known [16];
`ifdef IBEX_DATA_RESP_INTG_EN
  function automatic logic [6:0] enc(input logic [31:0] d);
    logic [38:0] x;
    x = {7'h0, d};
    return {^(x & 39'h0098505586), ^(x & 39'h002DCC624C), ^(x & 39'h00C2C1323B),
            ^(x & 39'h0031234ED1), ^(x & 39'h00413D89AA), ^(x & 39'h00DEBA8050),
            ^(x & 39'h002606BD25)} ^ 7'h2A;
  endfunction
  function automatic logic [6:0] good_intg(input logic [31:0] d);
    return enc(d);
  endfunction
  function automatic logic [6:0] exp_intg(input logic [31:0] d);
    return enc(d);
  endfunction
`else
  function automatic logic [6:0] good_intg(input logic [31:0] d);
    return 7'($urandom) ^ 7'(d[0]);
  endfunction
  function automatic logic [6:0] exp_intg(input logic [31:0] d);
    return 7'(d[0]) & 7'h0;
  endfunction
`endif
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  task automatic txn(input string n, input logic w, input logic [3:0] b, input logic [31:0] a,
                     input logic [32:0] d, input logic fl, input logic [32:0] exp_rd, input logic exp_e);
    int lat;
    logic [32:0] rd;
    logic e;
    logic [6:0] ri;
    @(posedge clk); #1;
    bus.req = 1'b1; bus.we = w; bus.be = b; bus.addr = a; bus.wdata = d;
    bus.wdata_intg = good_intg(d[31:0]) ^ {6'h0, fl};
    @(negedge clk);
    chk({n, " gnt"}, bus.gnt, 1);
    @(posedge clk); #1;
    bus.req = 1'b0;
    lat = 0; rd = '0; e = 1'b0; ri = '0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (bus.rvalid && lat == 0) begin lat = k; rd = bus.rdata; e = bus.err; ri = bus.rdata_intg; end
    end
    chk({n, " latency"}, lat, 2);
    chk({n, " rdata"}, rd, exp_rd);
    chk({n, " err"}, e, exp_e);
    chk({n, " intg"}, ri, exp_intg(exp_rd[31:0]));
  endtask
  task automatic step(input logic r, input logic w, input logic s, input logic [3:0] b,
                      input logic [31:0] a, input logic [32:0] d);
    logic eg, bad;
    int k;
    logic [32:0] rd, nw;
    @(posedge clk); #1;
    bus.req = r; bus.we = w; bus.be = b; bus.addr = a; bus.wdata = d;
    bus.wdata_intg = good_intg(d[31:0]); stall = s;
    @(negedge clk);
    eg = r & ~s & (q.size() < 2);
    chk("gnt", bus.gnt, eg);
    if (q.size() > 0 && q[0].due == cyc) begin
      chk("rvalid", bus.rvalid, 1);
      chk("rdata", bus.rdata, q[0].d);
      chk("err", bus.err, q[0].e);
      chk("rdata_intg", bus.rdata_intg, exp_intg(q[0].d[31:0]));
      void'(q.pop_front());
    end else begin
      chk("idle rvalid", bus.rvalid, 0);
      chk("idle rdata", bus.rdata, 0);
      chk("idle err", bus.err, 0);
    end
    if (eg) begin
      bad = (a < MB) || (a >= MB + 32'd4096) || (a[1:0] != 2'b00);
      k = int'((a - MB) >> 2) & 1023;
      rd = '0;
      if (!bad && !w) rd = mmem[k];
      if (!bad && w) begin
        nw = mmem[k];
        for (int i = 0; i < 4; i++) if (b[i]) nw[8*i +: 8] = d[8*i +: 8];
        nw[32] = (b == 4'hF) ? d[32] : 1'b0;
        mmem[k] = nw;
      end
      q.push_back('{cyc + 2, rd, bad});
    end
    cyc++;
  endtask
  initial begin
    logic [31:0] a;
    logic [3:0] b;
    logic w;
    int k;
    logic [5:0] pat;
    tbl[0]  = '{1, 4'hF, MB + 32'h10,  33'h1_DEADBEEF, 33'h0,          0};
    tbl[1]  = '{0, 4'hF, MB + 32'h10,  33'h0,          33'h1_DEADBEEF, 0};
    tbl[2]  = '{1, 4'h2, MB + 32'h10,  33'h0_0000AB00, 33'h0,          0};
    tbl[3]  = '{0, 4'hF, MB + 32'h10,  33'h0,          33'h0_DEADABEF, 0};
    tbl[4]  = '{0, 4'hF, MB - 32'h4,   33'h0,          33'h0,          1};
    tbl[5]  = '{0, 4'hF, MB + 32'h2,   33'h0,          33'h0,          1};
    tbl[6]  = '{1, 4'hF, MB + 32'h12,  33'h1_FFFFFFFF, 33'h0,          1};
    tbl[7]  = '{1, 4'hF, MB + 32'h1000, 33'h1_FFFFFFFF, 33'h0,         1};
    tbl[8]  = '{0, 4'hF, MB + 32'h10,  33'h0,          33'h0_DEADABEF, 0};
    tbl[9]  = '{1, 4'hF, MB + 32'hFFC, 33'h1_12345678, 33'h0,          0};
    tbl[10] = '{1, 4'h0, MB + 32'hFFC, 33'h1_99999999, 33'h0,          0};
    tbl[11] = '{0, 4'hF, MB + 32'hFFC, 33'h0,          33'h0_12345678, 0};
    tbl[12] = '{1, 4'hF, MB + 32'h14,  33'h1_CAFEF00D, 33'h0,          0};
    tbl[13] = '{0, 4'hF, MB + 32'h14,  33'h0,          33'h1_CAFEF00D, 0};
    for (int i = 0; i < 16; i++) known[i] = 1'b0;
    bus.req = 0; bus.we = 0; bus.be = 0; bus.addr = 0; bus.wdata = 0; bus.wdata_intg = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset rvalid", bus.rvalid, 0);
    chk("reset rdata", bus.rdata, 0);
    chk("reset err", bus.err, 0);
    chk("reset intg", bus.rdata_intg, 0);
    chk("reset gnt", bus.gnt, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 14; i++)
      txn($sformatf("vec%0d", i), tbl[i].we, tbl[i].be, tbl[i].addr, tbl[i].wdata, 1'b0,
          tbl[i].exp_rdata, tbl[i].exp_err);
`ifdef IBEX_DATA_RESP_INTG_EN
    txn("bad intg write", 1, 4'hF, MB + 32'h10, 33'h1_11111111, 1'b1, 33'h0, 1);
    txn("read after bad intg", 0, 4'hF, MB + 32'h10, 33'h0, 1'b0, 33'h0_DEADABEF, 0);
`endif
    for (int n = 0; n < 400; n++) begin
      k = $urandom_range(0, 19);
      w = 1'($urandom);
      b = 4'($urandom);
      if (k < 16) begin
        a = MB + 32'(4 * k);
        if (!known[k]) begin w = 1'b1; b = 4'hF; end
      end else a = (k == 16) ? MB - 32'h4 : (k == 17) ? MB + 32'h2 : (k == 18) ? MB + 32'h1000 : MB + 32'hFFD;
      step($urandom_range(0, 3) != 0, w, $urandom_range(0, 4) == 0, b, a, {1'($urandom), 32'($urandom)});
      if (k < 16 && q.size() > 0 && q[q.size()-1].due == cyc + 1 && w) known[k] = 1'b1;
    end
    repeat (3) step(0, 0, 0, 4'h0, MB, 33'h0);
    step(1, 1, 0, 4'hF, MB, 33'h1_0BADF00D);
    repeat (3) step(0, 0, 0, 4'h0, MB, 33'h0);
    pat = 6'b011011;
    for (int i = 0; i < 6; i++) begin
      step(1, 0, 0, 4'hF, MB, 33'h0);
      chk($sformatf("gnt pattern %0d", i), bus.gnt, pat[i]);
    end
    repeat (3) step(0, 0, 0, 4'h0, MB, 33'h0);
    step(1, 0, 0, 4'hF, MB, 33'h0);
    step(1, 0, 0, 4'hF, MB, 33'h0);
    @(posedge clk); #1;
    bus.req = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    chk("rvalid in reset", bus.rvalid, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    q.delete();
    repeat (4) step(0, 0, 0, 4'h0, MB, 33'h0);
    step(1, 0, 0, 4'hF, MB, 33'h0);
    chk("gnt after reset", bus.gnt, 1);
    repeat (3) step(0, 0, 0, 4'h0, MB, 33'h0);
    chk("queue drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
